// File: rtl/dmem_resp.sv
// dmem_resp: word-organised data memory with RV32I byte/half/word sizing,
// a configurable wait latency and a valid/ready response handshake.
module dmem_resp #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic        ready_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [2:0]  funct3_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;
    logic [31:0] mem_r [DEPTH_WORDS];

    logic          accept_s;
    logic          enter_resp_s;
    logic          src_we_s;
    logic [31:0]   src_addr_s;
    logic [31:0]   src_wdata_s;
    logic [2:0]    src_funct3_s;
    logic [AW-1:0] idx_s;
    logic [1:0]    lane_s;
    logic          err_s;
    logic [3:0]    be_s;
    logic [31:0]   wd_s;
    logic [31:0]   word_s;
    logic [31:0]   load_s;
    logic          mem_we_s;

    function automatic logic access_err(input logic we, input logic [31:0] addr,
                                        input logic [2:0] f3);
        logic range_e;
        logic align_e;
        logic code_e;
        range_e = (addr[31:AW+2] != '0);
        case (f3)
            3'b000, 3'b100: begin align_e = 1'b0;                  code_e = 1'b0; end
            3'b001, 3'b101: begin align_e = addr[0];               code_e = 1'b0; end
            3'b010:         begin align_e = (addr[1:0] != 2'b00);  code_e = 1'b0; end
            default:        begin align_e = 1'b0;                  code_e = 1'b1; end
        endcase
        return range_e | align_e | code_e | (we & f3[2]);
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [2:0] f3);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b010:  r = word;
            3'b100:  r = {24'h00_0000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // With zero latency the access happens on the accepting edge, so use the live inputs there.
    always_comb begin
        if (state_r == IDLE) begin
            src_we_s     = req_we;
            src_addr_s   = req_addr;
            src_wdata_s  = req_wdata;
            src_funct3_s = req_funct3;
        end else begin
            src_we_s     = we_r;
            src_addr_s   = addr_r;
            src_wdata_s  = wdata_r;
            src_funct3_s = funct3_r;
        end
    end

    // Decode of the access: word/lane, fault, byte enables and extended load data.
    always_comb begin
        idx_s  = src_addr_s[AW+1:2];
        lane_s = src_addr_s[1:0];
        err_s  = access_err(src_we_s, src_addr_s, src_funct3_s);
        wd_s   = src_wdata_s << {lane_s, 3'b000};
        word_s = mem_r[idx_s];
        case (src_funct3_s[1:0])
            2'b00:   be_s = 4'b0001 << lane_s;
            2'b01:   be_s = 4'b0011 << lane_s;
            2'b10:   be_s = 4'b1111;
            default: be_s = 4'b0000;
        endcase
        if (err_s || src_we_s) begin
            load_s = 32'h0000_0000;
        end else begin
            load_s = load_ext(word_s, lane_s, src_funct3_s);
        end
    end

    // The edge that enters RESP is the one that performs the memory access.
    always_comb begin
        accept_s = req_valid && (state_r == IDLE);
        if (accept_s && (LATENCY == 0)) begin
            enter_resp_s = 1'b1;
        end else if ((state_r == BUSY) && (cnt_r == 3'd0)) begin
            enter_resp_s = 1'b1;
        end else begin
            enter_resp_s = 1'b0;
        end
        mem_we_s = enter_resp_s && src_we_s && !err_s && !reset;
    end

    // Byte-lane memory writes; memory is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[idx_s][b*8 +: 8] <= wd_s[b*8 +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            ready_r      <= 1'b1;
            we_r         <= 1'b0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            funct3_r     <= 3'b000;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r     <= req_we;
                        addr_r   <= req_addr;
                        wdata_r  <= req_wdata;
                        funct3_r <= req_funct3;
                        ready_r  <= 1'b0;
                        if (LATENCY == 0) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= load_s;
                            resp_err_r   <= err_s;
                        end else begin
                            state_r <= BUSY;
                            cnt_r   <= 3'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt_r == 3'd0) begin
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= load_s;
                        resp_err_r   <= err_s;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_r      <= IDLE;
                        ready_r      <= 1'b1;
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'h0000_0000;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    ready_r      <= 1'b1;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: byte-array reference model with per-cycle comparison,
// directed scenarios with literal expectations, random traffic, and a LATENCY=0 instance.
module tb_dmem_resp;
    localparam int LAT  = 2;
    localparam int MEMW = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        z_valid, z_ready, z_we, z_resp_valid, z_err;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [2:0]  z_f3;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem_b [0:4*MEMW-1];
    bit          m_busy = 1'b0, m_done = 1'b0, seen_rst = 1'b0, m_err = 1'b0;
    int          cyc = 0, m_acc = 0;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_f3;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH_WORDS(MEMW), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_resp #(.DEPTH_WORDS(MEMW), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(z_valid), .req_ready(z_ready),
        .req_we(z_we), .req_addr(z_addr), .req_wdata(z_wdata), .req_funct3(z_f3),
        .resp_valid(z_resp_valid), .resp_ready(1'b1), .resp_rdata(z_rdata), .resp_err(z_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference access on a flat byte array: fault rules, then little-endian byte copy.
    function automatic void ref_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                       input logic [2:0] f3, output logic [31:0] rd, output bit er);
        int nb;
        int base;
        logic [63:0] v;
        nb = 1 << f3[1:0];
        er = ((a >> 2) >= 32'(MEMW)) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)
             || (we && f3[2]) || ((a & 32'(nb - 1)) != 32'd0);
        rd = 32'd0;
        if (!er) begin
            base = int'(a);
            if (we) begin
                for (int i = 0; i < nb; i++) mem_b[base + i] = wd[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_b[base + i];
                if (!f3[2] && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
                rd = v[31:0];
            end
        end
    endfunction

    // Model update on each rising edge, comparison on each falling edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_busy   = 1'b0;
                m_done   = 1'b0;
                seen_rst = 1'b1;
            end else if (seen_rst) begin
                if (m_busy && m_done && resp_ready) begin
                    m_busy = 1'b0;
                end else if (!m_busy && req_valid) begin
                    m_busy = 1'b1; m_done = 1'b0; m_acc = cyc;
                    m_we = req_we; m_addr = req_addr; m_wdata = req_wdata; m_f3 = req_funct3;
                end
                if (m_busy && !m_done && cyc == m_acc + LAT) begin
                    ref_access(m_we, m_addr, m_wdata, m_f3, m_rdata, m_err);
                    m_done = 1'b1;
                end
            end
            @(negedge clk);
            if (seen_rst) begin
                chk("req_ready", 32'(req_ready), 32'(!m_busy));
                chk("resp_valid", 32'(resp_valid), 32'(m_busy && m_done));
                if (m_busy && m_done) begin
                    chk("resp_rdata", resp_rdata, m_rdata);
                    chk("resp_err", 32'(resp_err), 32'(m_err));
                end
            end
        end
    end

    task automatic junk(input bit pend);
        req_valid  = pend ? 1'b1 : 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int hold, input bit pend,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_now("accept_wait");
        @(posedge clk);
        @(negedge clk);
        junk(pend);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            lat++;
            @(negedge clk);
            junk(pend);
        end
        if (lat >= 20) fail_now("resp_wait");
        rd = resp_rdata;
        er = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            junk(pend);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_err", 32'(resp_err), 32'(er));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] a;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_funct3 = 3'd0; resp_ready = 1'b0;
        z_valid = 1'b0; z_we = 1'b0; z_addr = 32'd0; z_wdata = 32'd0; z_f3 = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_z_ready", 32'(z_ready), 32'd1);
        reset = 1'b0;

        for (int w = 0; w < MEMW; w++) do_req(1'b1, 32'(w * 4), $urandom, 3'b010, 0, 1'b0, rd, er, lat);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 1'b0, rd, er, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_err", 32'(er), 32'd0);
        do_req(1'b0, 32'h10, 32'd0, 3'b010, 0, 1'b0, rd, er, lat);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_beef", rd, 32'hDEADBEEF);
        chk("lw_beef_err", 32'(er), 32'd0);

        do_req(1'b1, 32'h10, 32'h0, 3'b010, 0, 1'b0, rd, er, lat);
        do_req(1'b1, 32'h11, 32'h000000A5, 3'b000, 0, 1'b0, rd, er, lat);
        do_req(1'b0, 32'h11, 32'd0, 3'b000, 0, 1'b0, rd, er, lat);
        chk("lb_sext", rd, 32'hFFFFFFA5);
        do_req(1'b0, 32'h11, 32'd0, 3'b100, 0, 1'b0, rd, er, lat);
        chk("lbu_zext", rd, 32'h000000A5);
        do_req(1'b0, 32'h10, 32'd0, 3'b010, 0, 1'b0, rd, er, lat);
        chk("lw_after_sb", rd, 32'h0000A500);

        do_req(1'b0, 32'h13, 32'd0, 3'b001, 0, 1'b0, rd, er, lat);
        chk("lh_mis_err", 32'(er), 32'd1);
        chk("lh_mis_rdata", rd, 32'd0);
        do_req(1'b1, 32'h12, 32'hFFFFFFFF, 3'b010, 0, 1'b0, rd, er, lat);
        chk("sw_mis_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h100, 32'd0, 3'b010, 0, 1'b0, rd, er, lat);
        chk("lw_oor_err", 32'(er), 32'd1);
        chk("lw_oor_rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 32'd0, 3'b011, 0, 1'b0, rd, er, lat);
        chk("f3_011_err", 32'(er), 32'd1);
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, 0, 1'b0, rd, er, lat);
        chk("sbu_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h10, 32'd0, 3'b010, 5, 1'b1, rd, er, lat);
        chk("mem_unchanged", rd, 32'h0000A500);

        do_req(1'b1, 32'h20, 32'h11112222, 3'b010, 0, 1'b0, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        do_req(1'b0, 32'h20, 32'd0, 3'b010, 0, 1'b0, rd, er, lat);
        chk("abort_old_val", rd, 32'h11112222);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'hCAFEF00D; req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("resp_before_rst", 32'(resp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("resp_dropped", 32'(resp_valid), 32'd0);
        do_req(1'b0, 32'h24, 32'd0, 3'b010, 0, 1'b0, rd, er, lat);
        chk("committed_kept", rd, 32'hCAFEF00D);

        for (int r = 0; r < 200; r++) begin
            a = 32'($urandom_range(0, 32'h117));
            do_req(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), 1'b0, rd, er, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        z_valid = 1'b1; z_we = 1'b1; z_addr = 32'h0; z_wdata = 32'h55AA1234; z_f3 = 3'b010;
        chk("z_idle_ready", 32'(z_ready), 32'd1);
        @(negedge clk);
        chk("z_sw_valid", 32'(z_resp_valid), 32'd1);
        chk("z_sw_busy", 32'(z_ready), 32'd0);
        chk("z_sw_rdata", z_rdata, 32'd0);
        chk("z_sw_err", 32'(z_err), 32'd0);
        z_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("z_gap_ready", 32'(z_ready), 32'd1);
            chk("z_gap_valid", 32'(z_resp_valid), 32'd0);
            @(negedge clk);
            chk("z_lw_valid", 32'(z_resp_valid), 32'd1);
            chk("z_lw_rdata", z_rdata, 32'h55AA1234);
            chk("z_lw_busy", 32'(z_ready), 32'd0);
        end
        z_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
